// File: rtl/demux_1to16_collect.sv
// Serial-to-parallel collector: steers accepted bits into a 16-bit word.
// Define DEMUX_COLLECT_MSB_FIRST_EN to fill from bit 15 down to bit 0.
module demux_1to16_collect (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic        in_data,
    input  logic        clear,
    output logic [3:0]  sel,
    output logic [3:0]  isel,
    output logic        busy,
    output logic [15:0] out_data,
    output logic        out_valid
);

`ifdef DEMUX_COLLECT_MSB_FIRST_EN
    localparam logic [3:0] START_POS = 4'hF;
    localparam logic [3:0] FINAL_POS = 4'h0;
    localparam logic [3:0] STEP      = 4'hF;
`else
    localparam logic [3:0] START_POS = 4'h0;
    localparam logic [3:0] FINAL_POS = 4'hF;
    localparam logic [3:0] STEP      = 4'h1;
`endif

    logic [3:0]  pos_q;
    logic [15:0] asm_q;
    logic [15:0] merged;

    always_comb begin
        merged         = asm_q;
        merged[pos_q]  = in_data;
    end

    // Position wraps naturally through 4-bit modular add in both directions
    always_ff @(posedge clk) begin
        if (rst) begin
            pos_q     <= START_POS;
            asm_q     <= 16'h0000;
            out_data  <= 16'h0000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            if (clear) begin
                pos_q <= START_POS;
                asm_q <= 16'h0000;
            end else if (in_valid) begin
                pos_q <= pos_q + STEP;
                if (pos_q == FINAL_POS) begin
                    out_data  <= merged;
                    out_valid <= 1'b1;
                    asm_q     <= 16'h0000;
                end else begin
                    asm_q <= merged;
                end
            end
        end
    end

    assign sel  = pos_q;
    assign isel = ~pos_q;
    assign busy = (pos_q != START_POS);

endmodule

// File: doc/demux_1to16_collect.md
DEMUX_1TO16_COLLECT -- requirements
Module: demux_1to16_collect

Interface
REQ-001 The block SHALL have no parameters; width is fixed at 16 data bits and 4 select bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 in_valid  input  1  qualifies in_data for one cycle; one bit accepted per cycle when high.
REQ-005 in_data  input  1  serial data bit.
REQ-006 clear  input  1  synchronous abort of the partially collected word.
REQ-007 sel  output  4  bit position the next accepted bit is written to.
REQ-008 isel  output  4  bitwise complement of sel.
REQ-009 busy  output  1  high while a partial word is held (position not at start).
REQ-010 out_data  output  16  last completed word.
REQ-011 out_valid  output  1  one-cycle pulse marking a new out_data value.

Function
REQ-012 An internal 4-bit position counter SHALL drive sel; isel SHALL equal ~sel combinationally at all times.
REQ-013 On an edge with in_valid=1 and clear=0, in_data SHALL be written into bit sel of a 16-bit assembly register; all other assembly bits SHALL hold.
REQ-014 On that accepting edge the counter SHALL step one position; stepping from the final position SHALL wrap to the start position.
REQ-015 On an accepting edge at the final position, out_data SHALL load the assembly register with the incoming bit merged at position sel, and out_valid SHALL be 1 in the following cycle only.
REQ-016 Latency SHALL be exactly one cycle from the 16th accepted bit to out_valid=1 with the word on out_data.
REQ-017 After completion, the assembly register SHALL clear to 0x0000 on the same edge.
REQ-018 out_data SHALL hold its value between completions; it SHALL NOT change on partial writes or clear.
REQ-019 in_valid=0 cycles SHALL leave counter, assembly register and out_data unchanged; gaps of any length are legal mid-word.
REQ-020 clear=1 SHALL set the counter to the start position and the assembly register to 0x0000 on that edge; clear has priority over a simultaneous in_valid, whose bit SHALL be discarded, and SHALL suppress a completion on that edge.
REQ-021 busy SHALL equal (sel != start position).
REQ-022 Back-to-back words (in_valid held high for 32 cycles) SHALL produce two out_valid pulses exactly 16 cycles apart with no lost bits.

Reset
REQ-023 On rst=1 at an edge: counter to start position, assembly register 0x0000, out_data 0x0000, out_valid 0; rst SHALL override clear and in_valid.
REQ-024 Reset mid-word SHALL discard the partial word; the first bit accepted after reset deassertion SHALL land at the start position.

Configuration
REQ-025 Macro DEMUX_COLLECT_MSB_FIRST_EN: when defined, start position SHALL be 15, counter SHALL decrement, final position 0; when undefined, start position 0, counter increments, final position 15.
REQ-026 After reset, sel SHALL read 4'hF with the macro defined and 4'h0 without it; isel correspondingly 4'h0 and 4'hF.

Verification
REQ-027 LSB-first build, rst then 16 accepted bits 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 -> out_valid=1 one cycle after the last bit, out_data=16'hA5C3, sel=0, busy=0.
REQ-028 Same stream with in_valid=0 gaps of 3 cycles between every bit -> identical out_data=16'hA5C3, single out_valid pulse, out_data unchanged during gaps.
REQ-029 8 bits accepted, then clear=1 with in_valid=1 -> sel=0, busy=0, no out_valid, out_data retains prior 16'hA5C3; the next 16 bits of 16'hFFFF -> out_data=16'hFFFF.
REQ-030 rst asserted after 5 bits of a word -> out_data=16'h0000, sel=0, isel=4'hF; next full word 16'h0001 -> out_data=16'h0001.
REQ-031 in_valid high 32 cycles streaming 16'h1234 then 16'hBEEF -> out_valid pulses 16 cycles apart, out_data 16'h1234 then 16'hBEEF.
REQ-032 MSB-first build, stream bits of 16'h8001 starting at bit 15 -> after reset sel=4'hF; out_data=16'h8001, out_valid pulse one cycle after 16th bit.
